// File: rtl/csa_accumulator.sv
// Streaming multi-operand adder: carry-save accumulation, one CPA per sum.
// Latency: last operand accepted at edge N -> o_out_valid high after edge N+2.
// Backpressure: o_in_ready low from last accept until the result is taken; result held stable.
module csa_accumulator #(
    parameter int WIDTH  = 64,
    parameter int GUARD  = 8,
    parameter int SIGNED = 0,
    parameter int ACC_W  = WIDTH + GUARD,
    parameter int CNT_W  = GUARD + 1
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic             i_in_last,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [ACC_W-1:0] o_out_sum,
    output logic [CNT_W-1:0] o_out_count,
    output logic             o_out_ovf
);

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_t;

    // Term count above this value means the guard bits may not have held the sum.
    localparam logic [CNT_W-1:0] OVF_LIMIT = {1'b1, {GUARD{1'b0}}};

    state_t           r_state;
    logic [ACC_W-1:0] r_s;
    logic [ACC_W-1:0] r_c;
    logic [CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0] r_sum;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic             r_valid;

    logic [ACC_W-1:0] w_x;
    logic [ACC_W-1:0] w_maj;
    logic [ACC_W-1:0] w_s_next;
    logic [ACC_W-1:0] w_c_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [ACC_W-1:0] w_cpa;
    logic             w_accept;

    // Operand extension, 3:2 compression and saturating term count for the accept path.
    always_comb begin
        w_x = '0;
        if (SIGNED != 0) begin
            w_x = {{GUARD{i_in_data[WIDTH-1]}}, i_in_data};
        end else begin
            w_x = {{GUARD{1'b0}}, i_in_data};
        end
        w_s_next   = r_s ^ r_c ^ w_x;
        w_maj      = (r_s & r_c) | (r_s & w_x) | (r_c & w_x);
        // Carry out of the top bit is dropped: the sum is modulo 2^ACC_W.
        w_c_next   = {w_maj[ACC_W-2:0], 1'b0};
        w_cnt_next = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        w_cpa      = r_s + r_c;
    end

    // Ready depends only on state, so there is no path from i_out_ready to o_in_ready.
    assign o_in_ready = (r_state == ST_ACCUM);
    assign w_accept   = i_in_valid & o_in_ready;

    // Control FSM with the redundant accumulator and registered result outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_ACCUM;
            r_s     <= '0;
            r_c     <= '0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_s   <= w_s_next;
                        r_c   <= w_c_next;
                        r_cnt <= w_cnt_next;
                        if (i_in_last) begin
                            r_state <= ST_RESOLVE;
                        end
                    end
                end
                ST_RESOLVE: begin
                    r_sum   <= w_cpa;
                    r_count <= r_cnt;
                    r_ovf   <= (r_cnt > OVF_LIMIT);
                    r_state <= ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    // First OUTPUT cycle raises valid; the handshake is only honoured once valid is up.
                    if (!r_valid) begin
                        r_valid <= 1'b1;
                    end else if (i_out_ready) begin
                        r_valid <= 1'b0;
                        r_s     <= '0;
                        r_c     <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_ACCUM;
                    end
                end
                default: begin
                    r_state <= ST_ACCUM;
                end
            endcase
        end
    end

    assign o_out_valid = r_valid;
    assign o_out_sum   = r_sum;
    assign o_out_count = r_count;
    assign o_out_ovf   = r_ovf;

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed bench for csa_accumulator across three parameter sets sharing one clock.
// Checks reset values, sums, counts, overflow flag, latency, backpressure and mid-op reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_csa_accumulator;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    // Instance A: WIDTH=64, GUARD=8, unsigned
    logic        a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_ovf;
    logic [63:0] a_in_data;
    logic [71:0] a_out_sum;
    logic [8:0]  a_out_count;

    // Instance B: WIDTH=8, GUARD=2, unsigned
    logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_ovf;
    logic [7:0]  b_in_data;
    logic [9:0]  b_out_sum;
    logic [2:0]  b_out_count;

    // Instance C: WIDTH=8, GUARD=8, signed
    logic        c_in_valid, c_in_ready, c_in_last, c_out_valid, c_out_ready, c_out_ovf;
    logic [7:0]  c_in_data;
    logic [15:0] c_out_sum;
    logic [8:0]  c_out_count;

    csa_accumulator #(.WIDTH(64), .GUARD(8), .SIGNED(0)) u_a (
        .i_clk(clk), .i_reset_n(reset_n),
        .i_in_valid(a_in_valid), .o_in_ready(a_in_ready), .i_in_data(a_in_data), .i_in_last(a_in_last),
        .o_out_valid(a_out_valid), .i_out_ready(a_out_ready),
        .o_out_sum(a_out_sum), .o_out_count(a_out_count), .o_out_ovf(a_out_ovf)
    );

    csa_accumulator #(.WIDTH(8), .GUARD(2), .SIGNED(0)) u_b (
        .i_clk(clk), .i_reset_n(reset_n),
        .i_in_valid(b_in_valid), .o_in_ready(b_in_ready), .i_in_data(b_in_data), .i_in_last(b_in_last),
        .o_out_valid(b_out_valid), .i_out_ready(b_out_ready),
        .o_out_sum(b_out_sum), .o_out_count(b_out_count), .o_out_ovf(b_out_ovf)
    );

    csa_accumulator #(.WIDTH(8), .GUARD(8), .SIGNED(1)) u_c (
        .i_clk(clk), .i_reset_n(reset_n),
        .i_in_valid(c_in_valid), .o_in_ready(c_in_ready), .i_in_data(c_in_data), .i_in_last(c_in_last),
        .o_out_valid(c_out_valid), .i_out_ready(c_out_ready),
        .o_out_sum(c_out_sum), .o_out_count(c_out_count), .o_out_ovf(c_out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One operand per call; valid is held across exactly one rising edge.
    task automatic send_a(input logic [63:0] d, input logic last);
        a_in_valid = 1'b1; a_in_data = d; a_in_last = last;
        @(negedge clk);
        a_in_valid = 1'b0; a_in_last = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d, input logic last);
        b_in_valid = 1'b1; b_in_data = d; b_in_last = last;
        @(negedge clk);
        b_in_valid = 1'b0; b_in_last = 1'b0;
    endtask

    task automatic send_c(input logic [7:0] d, input logic last);
        c_in_valid = 1'b1; c_in_data = d; c_in_last = last;
        @(negedge clk);
        c_in_valid = 1'b0; c_in_last = 1'b0;
    endtask

    // Called right after the last operand; expects valid exactly two edges after its accept.
    task automatic wait_a(input string tag);
        int n = 0;
        while (!a_out_valid && n < 10) begin @(negedge clk); n++; end
        chk(tag, 80'(n), 80'd2);
    endtask

    task automatic wait_b(input string tag);
        int n = 0;
        while (!b_out_valid && n < 10) begin @(negedge clk); n++; end
        chk(tag, 80'(n), 80'd2);
    endtask

    task automatic wait_c(input string tag);
        int n = 0;
        while (!c_out_valid && n < 10) begin @(negedge clk); n++; end
        chk(tag, 80'(n), 80'd2);
    endtask

    task automatic take_a();
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        chk("a_take_valid", 80'(a_out_valid), 80'd0);
        chk("a_take_ready", 80'(a_in_ready), 80'd1);
    endtask

    initial begin
        total = 0; bad = 0;
        reset_n = 1'b0;
        a_in_valid = 0; a_in_data = '0; a_in_last = 0; a_out_ready = 0;
        b_in_valid = 0; b_in_data = '0; b_in_last = 0; b_out_ready = 0;
        c_in_valid = 0; c_in_data = '0; c_in_last = 0; c_out_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 80'(a_out_valid), 80'd0);
        chk("rst_sum",   80'(a_out_sum),   80'd0);
        chk("rst_count", 80'(a_out_count), 80'd0);
        chk("rst_ovf",   80'(a_out_ovf),   80'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 80'(a_in_ready), 80'd1);

        // 5 + 7 + 9
        send_a(64'd5, 1'b0);
        send_a(64'd7, 1'b0);
        send_a(64'd9, 1'b1);
        chk("t1_busy", 80'(a_in_ready), 80'd0);
        wait_a("t1_latency");
        chk("t1_sum",   80'(a_out_sum),   80'd21);
        chk("t1_count", 80'(a_out_count), 80'd3);
        chk("t1_ovf",   80'(a_out_ovf),   80'd0);
        take_a();

        // Single-term sum, then backpressure with a stray operand offered
        send_a(64'hDEAD, 1'b1);
        wait_a("t2_latency");
        chk("t2_sum",   80'(a_out_sum),   80'hDEAD);
        chk("t2_count", 80'(a_out_count), 80'd1);
        a_in_valid = 1'b1; a_in_data = 64'h55; a_in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_valid", 80'(a_out_valid), 80'd1);
            chk("t5_sum",   80'(a_out_sum),   80'hDEAD);
            chk("t5_count", 80'(a_out_count), 80'd1);
            chk("t5_ready", 80'(a_in_ready),  80'd0);
        end
        a_in_valid = 1'b0; a_in_last = 1'b0;
        take_a();
        send_a(64'd4, 1'b1);
        wait_a("t5_latency");
        chk("t5_next_sum",   80'(a_out_sum),   80'd4);
        chk("t5_next_count", 80'(a_out_count), 80'd1);
        take_a();

        // Large operands wrap modulo 2^72 only beyond guard range: 2 * (2^64-1)
        send_a(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send_a(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        wait_a("wide_latency");
        chk("wide_sum", 80'(a_out_sum), 80'h1_FFFF_FFFF_FFFF_FFFE);
        take_a();

        // Reset while a result is pending
        send_a(64'd7, 1'b1);
        wait_a("rp_latency");
        reset_n = 1'b0;
        #1;
        chk("rp_valid", 80'(a_out_valid), 80'd0);
        chk("rp_sum",   80'(a_out_sum),   80'd0);
        chk("rp_count", 80'(a_out_count), 80'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset after 2 of 4 operands discards the partial sum
        send_a(64'd100, 1'b0);
        send_a(64'd200, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("t6_valid", 80'(a_out_valid), 80'd0);
        chk("t6_sum",   80'(a_out_sum),   80'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send_a(64'd1, 1'b0);
        send_a(64'd2, 1'b1);
        wait_a("t6_latency");
        chk("t6_sum2",   80'(a_out_sum),   80'd3);
        chk("t6_count2", 80'(a_out_count), 80'd2);
        take_a();

        // Five 0xFF terms into a 10-bit accumulator: 1275 mod 1024 = 251, count 5 > 4
        chk("b_ready", 80'(b_in_ready), 80'd1);
        for (int i = 0; i < 5; i++) send_b(8'hFF, (i == 4));
        wait_b("t3_latency");
        chk("t3_sum",   80'(b_out_sum),   80'd251);
        chk("t3_count", 80'(b_out_count), 80'd5);
        chk("t3_ovf",   80'(b_out_ovf),   80'd1);
        b_out_ready = 1'b1; @(negedge clk); b_out_ready = 1'b0;

        // Four terms: at the 2^GUARD limit, no overflow flag
        for (int i = 0; i < 4; i++) send_b(8'd3, (i == 3));
        wait_b("lim_latency");
        chk("lim_sum",   80'(b_out_sum),   80'd12);
        chk("lim_count", 80'(b_out_count), 80'd4);
        chk("lim_ovf",   80'(b_out_ovf),   80'd0);
        b_out_ready = 1'b1; @(negedge clk); b_out_ready = 1'b0;

        // Nine terms: count saturates at 7
        for (int i = 0; i < 9; i++) send_b(8'd1, (i == 8));
        wait_b("sat_latency");
        chk("sat_sum",   80'(b_out_sum),   80'd9);
        chk("sat_count", 80'(b_out_count), 80'd7);
        chk("sat_ovf",   80'(b_out_ovf),   80'd1);
        b_out_ready = 1'b1; @(negedge clk); b_out_ready = 1'b0;
        chk("b_idle", 80'(b_out_valid), 80'd0);

        // Signed: -3 + 2 = -1 in 16 bits
        chk("c_ready", 80'(c_in_ready), 80'd1);
        send_c(8'hFD, 1'b0);
        send_c(8'h02, 1'b1);
        wait_c("t4_latency");
        chk("t4_sum",   80'(c_out_sum),   80'hFFFF);
        chk("t4_count", 80'(c_out_count), 80'd2);
        chk("t4_ovf",   80'(c_out_ovf),   80'd0);
        c_out_ready = 1'b1; @(negedge clk); c_out_ready = 1'b0;

        // Signed: -128 + -128 = -256 = 0xFF00
        send_c(8'h80, 1'b0);
        send_c(8'h80, 1'b1);
        wait_c("neg_latency");
        chk("neg_sum", 80'(c_out_sum), 80'hFF00);
        c_out_ready = 1'b1; @(negedge clk); c_out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
